cache_arbiter: RTL and testbench

- Arbitrates the 8 KB byte-wide boot/cache RAM between two requesters: the instruction-fetch port (IF) and the load/store port (MEM).
- Each granted access is split into 1, 2 or 4 sequential byte transactions using the RAM's request / `o_data_DV` handshake.
- Read bytes are assembled little-endian into a 32-bit word, and a single completion pulse is returned to the winning requester.

---
 rtl/cache_arb_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/cache_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cache_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and encodings for the boot/cache RAM arbiter.
package cache_arb_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int DRAIN_CYCLES = 4;

  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_count = 3'd1;
      SIZE_HALF: size_to_count = 3'd2;
      default:   size_to_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the last winner loses the next tie.
module rr_arbiter2
  import cache_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_update_id,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic last_grant_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant_q <= REQ_MEM;
    end else if (i_update) begin
      last_grant_q <= i_update_id;
    end
  end

  always_comb begin
    o_gnt_valid = |i_req;
    if (&i_req) begin
      o_gnt_id = ~last_grant_q;
    end else begin
      o_gnt_id = i_req[REQ_MEM] ? REQ_MEM : REQ_IF;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the byte-wide boot/cache RAM between instruction fetch and load/store,
// splitting each access into sequential byte transactions.
//
// state    | meaning
// ST_DRAIN | post-reset wait so a stale RAM DV cannot be mistaken for a new one
// ST_IDLE  | arbitrate and latch the winning request
// ST_ISSUE | one-cycle RAM request for the current byte
// ST_WAIT  | hold RAM outputs until the byte's DV
// ST_DONE  | one-cycle completion pulse to the granted requester
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_request,
  input  logic [ADDR_WIDTH-1:0] i_if_address,
  output logic [WORD_WIDTH-1:0] o_if_data,
  output logic                  o_if_data_DV,
  input  logic                  i_mem_request,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_mem_size,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [WORD_WIDTH-1:0] i_mem_data,
  output logic [WORD_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_data_DV,
  output logic                  o_cache_request,
  output logic                  o_cache_write,
  output logic [ADDR_WIDTH-1:0] o_cache_address,
  output logic [DATA_WIDTH-1:0] o_cache_data,
  input  logic [DATA_WIDTH-1:0] i_cache_data,
  input  logic                  i_cache_data_DV
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [2:0]            drain_cnt_q;
  logic                  req_id_q, write_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [2:0]            count_q, idx_q;
  logic [WORD_WIDTH-1:0] wdata_q, rbuf_q;

  logic                  cache_req_q, cache_write_q;
  logic [ADDR_WIDTH-1:0] cache_addr_q;
  logic [DATA_WIDTH-1:0] cache_data_q;

  logic                  gnt_valid, gnt_id, gnt_is_mem;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [2:0]            issue_idx;
  logic [ADDR_WIDTH-1:0] issue_base;
  logic                  issue_write;
  logic [WORD_WIDTH-1:0] issue_wdata;

  rr_arbiter2 u_rr (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       ({i_mem_request, i_if_request}),
    .i_update    (state_q == ST_DONE),
    .i_update_id (req_id_q),
    .o_gnt_valid (gnt_valid),
    .o_gnt_id    (gnt_id)
  );

  assign gnt_is_mem = (gnt_id == REQ_MEM);
  assign gnt_addr   = gnt_is_mem ? i_mem_address : i_if_address;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRAIN: if (drain_cnt_q == 3'd0) state_d = ST_IDLE;
      ST_IDLE:  if (gnt_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_cache_data_DV) begin
          state_d = (idx_q + 3'd1 == count_q) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_DRAIN;
    endcase
  end

  // RAM outputs are loaded on entry to ISSUE, so the first byte comes straight
  // from the grant and later bytes from the latched access.
  always_comb begin
    if (state_q == ST_IDLE) begin
      issue_idx   = 3'd0;
      issue_base  = gnt_addr;
      issue_write = gnt_is_mem & i_mem_write;
      issue_wdata = gnt_is_mem ? i_mem_data : '0;
    end else begin
      issue_idx   = idx_q + 3'd1;
      issue_base  = base_q;
      issue_write = write_q;
      issue_wdata = wdata_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_DRAIN;
      drain_cnt_q   <= DRAIN_LOAD;
      req_id_q      <= REQ_IF;
      write_q       <= 1'b0;
      base_q        <= '0;
      count_q       <= 3'd0;
      idx_q         <= 3'd0;
      wdata_q       <= '0;
      rbuf_q        <= '0;
      cache_req_q   <= 1'b0;
      cache_write_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cache_req_q <= (state_d == ST_ISSUE);

      if (state_q == ST_DRAIN && drain_cnt_q != 3'd0) begin
        drain_cnt_q <= drain_cnt_q - 3'd1;
      end

      if (state_d == ST_ISSUE) begin
        cache_addr_q  <= issue_base + ADDR_WIDTH'(issue_idx);
        cache_write_q <= issue_write;
        cache_data_q  <= issue_wdata[{issue_idx[1:0], 3'b000} +: DATA_WIDTH];
      end

      if (state_q == ST_IDLE && gnt_valid) begin
        req_id_q <= gnt_id;
        base_q   <= gnt_addr;
        write_q  <= gnt_is_mem & i_mem_write;
        count_q  <= gnt_is_mem ? size_to_count(i_mem_size) : 3'd4;
        wdata_q  <= gnt_is_mem ? i_mem_data : '0;
        idx_q    <= 3'd0;
        rbuf_q   <= '0;
      end

      if (state_q == ST_WAIT && i_cache_data_DV) begin
        idx_q <= idx_q + 3'd1;
        if (!write_q) begin
          rbuf_q[{idx_q[1:0], 3'b000} +: DATA_WIDTH] <= i_cache_data;
        end
      end
    end
  end

  assign o_cache_request = cache_req_q;
  assign o_cache_write   = cache_write_q;
  assign o_cache_address = cache_addr_q;
  assign o_cache_data    = cache_data_q;

  assign o_if_data_DV  = (state_q == ST_DONE) && (req_id_q == REQ_IF);
  assign o_mem_data_DV = (state_q == ST_DONE) && (req_id_q == REQ_MEM);
  assign o_if_data     = o_if_data_DV ? rbuf_q : '0;
  assign o_mem_data    = (o_mem_data_DV && !write_q) ? rbuf_q : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter with a 4-cycle-latency byte RAM model.
module tb_cache_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_if_request = 1'b0;
  logic [12:0] i_if_address = '0;
  logic [31:0] o_if_data;
  logic        o_if_data_DV;
  logic        i_mem_request = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_mem_size = 2'b00;
  logic [12:0] i_mem_address = '0;
  logic [31:0] i_mem_data = '0;
  logic [31:0] o_mem_data;
  logic        o_mem_data_DV;
  logic        o_cache_request;
  logic        o_cache_write;
  logic [12:0] o_cache_address;
  logic [7:0]  o_cache_data;
  logic [7:0]  i_cache_data = '0;
  logic        i_cache_data_DV = 1'b0;

  cache_arbiter dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_if_request    (i_if_request),
    .i_if_address    (i_if_address),
    .o_if_data       (o_if_data),
    .o_if_data_DV    (o_if_data_DV),
    .i_mem_request   (i_mem_request),
    .i_mem_write     (i_mem_write),
    .i_mem_size      (i_mem_size),
    .i_mem_address   (i_mem_address),
    .i_mem_data      (i_mem_data),
    .o_mem_data      (o_mem_data),
    .o_mem_data_DV   (o_mem_data_DV),
    .o_cache_request (o_cache_request),
    .o_cache_write   (o_cache_write),
    .o_cache_address (o_cache_address),
    .o_cache_data    (o_cache_data),
    .i_cache_data    (i_cache_data),
    .i_cache_data_DV (i_cache_data_DV)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  // RAM model: not reset, so a request in flight still returns its DV.
  logic [7:0]  ram [0:8191];
  int          ram_cnt = 0;
  logic [12:0] ram_addr = '0;

  always @(posedge i_clk) begin
    i_cache_data_DV <= 1'b0;
    if (ram_cnt > 0) begin
      ram_cnt <= ram_cnt - 1;
      if (ram_cnt == 1) begin
        i_cache_data_DV <= 1'b1;
        i_cache_data    <= ram[ram_addr];
      end
    end
    if (o_cache_request) begin
      ram_cnt  <= 3;
      ram_addr <= o_cache_address;
      if (o_cache_write) ram[o_cache_address] <= o_cache_data;
    end
  end

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [12:0] req_log[$];
  int          n_req = 0;
  int          n_wr = 0;

  always @(negedge i_clk) begin
    exp_t e;
    if (o_cache_request) begin
      req_log.push_back(o_cache_address);
      n_req++;
      if (o_cache_write) n_wr++;
    end
    if (o_if_data_DV || o_mem_data_DV) begin
      chk("dv_onehot", 32'(o_if_data_DV & o_mem_data_DV), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dv_port", 32'(o_mem_data_DV), 32'(e.is_mem));
        chk("dv_data", o_mem_data_DV ? o_mem_data : o_if_data, e.data);
        chk("dv_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_req(input logic is_mem, input logic wr, input logic [1:0] sz,
                           input logic [12:0] a, input logic [31:0] wd,
                           input logic [31:0] expd, input int lat);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = expd;
    e.cyc    = cyc + lat;
    sb.push_back(e);
    if (is_mem) begin
      i_mem_request = 1'b1;
      i_mem_write   = wr;
      i_mem_size    = sz;
      i_mem_address = a;
      i_mem_data    = wd;
    end else begin
      i_if_request = 1'b1;
      i_if_address = a;
    end
  endtask

  task automatic wait_dv(input logic is_mem);
    int k = 0;
    while (!(is_mem ? o_mem_data_DV : o_if_data_DV) && k < 400) begin
      step();
      k++;
    end
    chk(is_mem ? "mem_dv_in_time" : "if_dv_in_time", 32'(k < 400), 32'd1);
    if (is_mem) i_mem_request = 1'b0;
    else i_if_request = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r0, w0, s;
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    ram[13'h0100] = 8'h11; ram[13'h0101] = 8'h22; ram[13'h0102] = 8'h33; ram[13'h0103] = 8'h44;
    ram[13'h0300] = 8'hDE; ram[13'h0301] = 8'hAD; ram[13'h0302] = 8'hBE; ram[13'h0303] = 8'hEF;
    ram[13'h1FFF] = 8'hBE; ram[13'h0000] = 8'hEF; ram[13'h0001] = 8'h77;
    ram[13'h0402] = 8'h11; ram[13'h0403] = 8'h22;

    repeat (3) step();
    chk("rst_ctrl", {28'd0, o_cache_request, o_cache_write, o_if_data_DV, o_mem_data_DV}, 32'd0);
    chk("rst_caddr", 32'(o_cache_address), 32'd0);
    chk("rst_cdata", 32'(o_cache_data), 32'd0);
    chk("rst_if_data", o_if_data, 32'd0);
    chk("rst_mem_data", o_mem_data, 32'd0);
    i_rst_n = 1'b1;

    // first cycle out of reset: DRAIN then a word read, DV at 25
    req_log.delete();
    start_req(1'b0, 1'b0, 2'b10, 13'h0100, 32'd0, 32'h44332211, 25);
    wait_dv(1'b0);
    chk("if_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("if_addr", 32'(req_log[i]), 32'h100 + 32'(i));

    // tie after an IF grant: MEM store wins, IF follows at the next IDLE
    step();
    w0 = n_wr;
    start_req(1'b1, 1'b1, 2'b00, 13'h0200, 32'h000000A5, 32'd0, 6);
    start_req(1'b0, 1'b0, 2'b10, 13'h0100, 32'd0, 32'h44332211, 28);
    wait_dv(1'b1);
    wait_dv(1'b0);
    chk("store_nwr", 32'(n_wr - w0), 32'd1);

    step();
    start_req(1'b1, 1'b0, 2'b00, 13'h0200, 32'd0, 32'h000000A5, 6);
    wait_dv(1'b1);

    // tie after a MEM grant: IF wins
    step();
    start_req(1'b0, 1'b0, 2'b10, 13'h0300, 32'd0, 32'hEFBEADDE, 21);
    start_req(1'b1, 1'b0, 2'b00, 13'h0200, 32'd0, 32'h000000A5, 28);
    wait_dv(1'b0);
    wait_dv(1'b1);

    // half load across the top of the address space
    step();
    req_log.delete();
    start_req(1'b1, 1'b0, 2'b01, 13'h1FFF, 32'd0, 32'h0000EFBE, 11);
    wait_dv(1'b1);
    chk("wrap_nreq", 32'(req_log.size()), 32'd2);
    chk("wrap_addr0", 32'(req_log[0]), 32'h1FFF);
    chk("wrap_addr1", 32'(req_log[1]), 32'h0000);

    // half store writes two lanes only; size 11 reads as a word
    step();
    w0 = n_wr;
    start_req(1'b1, 1'b1, 2'b01, 13'h0400, 32'hCAFEBABE, 32'd0, 11);
    wait_dv(1'b1);
    chk("half_nwr", 32'(n_wr - w0), 32'd2);
    step();
    start_req(1'b1, 1'b0, 2'b11, 13'h0400, 32'd0, 32'h2211BABE, 21);
    wait_dv(1'b1);

    // reset during the second byte's WAIT; request stays high and restarts
    step();
    s = cyc;
    start_req(1'b0, 1'b0, 2'b10, 13'h0300, 32'd0, 32'hEFBEADDE, 34);
    while (cyc < s + 8) step();
    req_log.delete();
    r0 = n_req;
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    repeat (4) step();
    chk("drain_nreq", 32'(n_req - r0), 32'd0);
    wait_dv(1'b0);
    chk("rst_nreq", 32'(req_log.size()), 32'd4);
    chk("rst_addr0", 32'(req_log[0]), 32'h0300);
    chk("rst_addr3", 32'(req_log[3]), 32'h0303);

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
